// File: rtl/digit_pkg.sv
// digit_pkg: shared FSM encoding, widths and border-address helper for the ROI sequencer
package digit_pkg;
  localparam int COORD_W = 11;
  localparam int IDX_W = 4;
  typedef enum logic [2:0] {
    IDLE, RD_TOP, RD_BOT, RD_LEFT, RD_RIGHT, CHECK, PRESENT, DONE
  } state_t;
  function automatic logic [IDX_W+1:0] border_addr(input logic [IDX_W-1:0] k, input logic hi);
    return {1'b0, k, 1'b0} + (hi ? 6'd2 : 6'd1);
  endfunction
endpackage

// File: rtl/digit_roi_sequencer_if.sv
// digit_roi_sequencer_if: ROI valid/ready bus towards the digit feature extractor
// master drives roi_valid, roi_x0/x1, roi_y0/y1, roi_idx, roi_last; slave drives roi_ready
interface digit_roi_sequencer_if;
  import digit_pkg::*;
  logic roi_valid;
  logic roi_ready;
  logic roi_last;
  logic [COORD_W-1:0] roi_x0, roi_x1, roi_y0, roi_y1;
  logic [IDX_W-1:0] roi_idx;
  modport master(output roi_valid, roi_x0, roi_x1, roi_y0, roi_y1, roi_idx, roi_last, input roi_ready);
  modport slave(input roi_valid, roi_x0, roi_x1, roi_y0, roi_y1, roi_idx, roi_last, output roi_ready);
endinterface

// File: rtl/border_fetch.sv
// border_fetch: one border-RAM read port with 1-cycle read latency
// req/addr load the read address; data_ok marks the cycle in which data holds the zero-extended RAM word
module border_fetch
  import digit_pkg::*;
#(
  parameter int DEPBIT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [DEPBIT-1:0]  addr,
  output logic [DEPBIT-1:0]  addr_rd,
  input  logic [DEPBIT-1:0]  data_rd,
  output logic [COORD_W-1:0] data,
  output logic               data_ok
);
  logic pend;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_rd <= '0;
      pend <= 1'b0;
      data_ok <= 1'b0;
    end else begin
      if (req) addr_rd <= addr;
      pend <= req;
      data_ok <= pend;
    end
  assign data = COORD_W'(data_rd);
endmodule

// File: rtl/digit_roi_sequencer.sv
// digit_roi_sequencer: reads row/column border pairs and issues one ROI per digit in row-major order
// project_done_flag (rising edge triggers), num_col/num_row counts, col/row border RAM read ports,
// roi bus (master), seq_busy/seq_done/seq_err/seq_ovr status
module digit_roi_sequencer
  import digit_pkg::*;
#(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4,
  parameter int DEPBIT = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                project_done_flag,
  input  logic [3:0]          num_col,
  input  logic [3:0]          num_row,
  output logic [DEPBIT-1:0]   col_border_addr_rd,
  input  logic [DEPBIT-1:0]   col_border_data_rd,
  output logic [DEPBIT-1:0]   row_border_addr_rd,
  input  logic [DEPBIT-1:0]   row_border_data_rd,
  digit_roi_sequencer_if.master roi,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                seq_err,
  output logic                seq_ovr
);
  localparam logic [IDX_W-1:0] NC = IDX_W'(NUM_COL);
  localparam logic [IDX_W-1:0] NR = IDX_W'(NUM_ROW);
  state_t state, state_nxt;
  logic flag_q, trig, clamp, bad, adv_c, adv_r, go;
  logic col_req, row_req, col_ok, row_ok;
  logic [IDX_W-1:0] nce, nre, nce_in, nre_in, c, r, c_nxt, r_nxt;
  logic [COORD_W-1:0] x0, x1, y0, y1, col_data, row_data;
  logic [DEPBIT-1:0] col_addr, row_addr;
  assign trig = project_done_flag & ~flag_q;
  assign nce_in = num_col > NC ? NC : num_col;
  assign nre_in = num_row > NR ? NR : num_row;
  assign clamp = (num_col > NC) || (num_row > NR);
  // unsigned compare also rejects bounds that wrapped below zero
  assign bad = (x1 <= x0) || (y1 <= y0);
  assign adv_c = (c + 4'd1) < nce;
  assign adv_r = (r + 4'd1) < nre;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      r <= '0;
    end else begin
      state <= state_nxt;
      c <= c_nxt;
      r <= r_nxt;
    end
  always_comb begin
    state_nxt = state;
    c_nxt = c;
    r_nxt = r;
    go = 1'b0;
    case (state)
      IDLE: if (trig) begin
        state_nxt = (nce_in == '0 || nre_in == '0) ? DONE : RD_TOP;
        c_nxt = '0;
        r_nxt = '0;
      end
      RD_TOP:   state_nxt = row_ok ? RD_BOT : RD_TOP;
      RD_BOT:   state_nxt = row_ok ? RD_LEFT : RD_BOT;
      RD_LEFT:  state_nxt = col_ok ? RD_RIGHT : RD_LEFT;
      RD_RIGHT: state_nxt = col_ok ? CHECK : RD_RIGHT;
      CHECK: begin
        state_nxt = PRESENT;
        go = bad;
      end
      PRESENT:  go = roi.roi_ready;
      default:  state_nxt = IDLE;
    endcase
    if (go) begin
      state_nxt = adv_c ? RD_LEFT : adv_r ? RD_TOP : DONE;
      c_nxt = adv_c ? c + 4'd1 : '0;
      r_nxt = (!adv_c && adv_r) ? r + 4'd1 : r;
    end
  end
  // fetch addresses follow the next state so each read state starts with its address already driven
  assign row_req = (state_nxt == RD_TOP || state_nxt == RD_BOT) && state_nxt != state;
  assign col_req = (state_nxt == RD_LEFT || state_nxt == RD_RIGHT) && state_nxt != state;
  assign row_addr = DEPBIT'(border_addr(r_nxt, state_nxt == RD_BOT));
  assign col_addr = DEPBIT'(border_addr(c_nxt, state_nxt == RD_RIGHT));
  border_fetch #(.DEPBIT(DEPBIT)) u_row (
    .clk, .rst_n, .req(row_req), .addr(row_addr), .addr_rd(row_border_addr_rd),
    .data_rd(row_border_data_rd), .data(row_data), .data_ok(row_ok)
  );
  border_fetch #(.DEPBIT(DEPBIT)) u_col (
    .clk, .rst_n, .req(col_req), .addr(col_addr), .addr_rd(col_border_addr_rd),
    .data_rd(col_border_data_rd), .data(col_data), .data_ok(col_ok)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_q <= 1'b0;
      nce <= '0;
      nre <= '0;
      x0 <= '0;
      x1 <= '0;
      y0 <= '0;
      y1 <= '0;
      seq_err <= 1'b0;
    end else begin
      flag_q <= project_done_flag;
      if (state == IDLE && trig) begin
        nce <= nce_in;
        nre <= nre_in;
        seq_err <= clamp;
      end else if (state == CHECK && bad) seq_err <= 1'b1;
      if (row_ok && state == RD_TOP) y0 <= row_data;
      if (row_ok && state == RD_BOT) y1 <= row_data;
      if (col_ok && state == RD_LEFT) x0 <= col_data;
      if (col_ok && state == RD_RIGHT) x1 <= col_data;
    end
  assign roi.roi_valid = state == PRESENT;
  assign roi.roi_x0 = x0;
  assign roi.roi_x1 = x1;
  assign roi.roi_y0 = y0;
  assign roi.roi_y1 = y1;
  assign roi.roi_idx = r * nce + c;
  assign roi.roi_last = state == PRESENT && r == nre - 4'd1 && c == nce - 4'd1;
  assign seq_busy = state != IDLE;
  assign seq_done = state == DONE;
  assign seq_ovr = trig && state != IDLE;
endmodule

// File: tb/tb_digit_roi_sequencer.sv
// tb_digit_roi_sequencer: randomized and directed checks of the ROI sequencer against a frame-level model
module tb_digit_roi_sequencer;
  import digit_pkg::*;
  localparam int NUM_ROW = 1;
  localparam int NUM_COL = 4;
  localparam int DEPBIT = 10;
  typedef struct packed {
    logic [10:0] x0, x1, y0, y1;
    logic [3:0] idx;
    logic last;
  } roi_t;
  logic clk = 0, rst_n = 0, flag = 0;
  logic [3:0] num_col = 0, num_row = 0;
  logic [DEPBIT-1:0] col_addr, col_data, row_addr, row_data;
  logic busy, done, err, ovr;
  logic [DEPBIT-1:0] col_mem [0:15];
  logic [DEPBIT-1:0] row_mem [0:15];
  int cb_lo[4], cb_hi[4], rb_lo[2], rb_hi[2];
  int cyc = 0, n_chk = 0, n_fail = 0, mode = 0, stall = 0;
  int done_cnt, done_edge, ovr_cnt, stab_viol, valid_cnt;
  int rise_q[$], xfer_q[$];
  roi_t got_q[$], exp_q[$];
  bit exp_err, pv, pr;
  roi_t po;
  digit_roi_sequencer_if roi_if();
  digit_roi_sequencer #(.NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .DEPBIT(DEPBIT)) dut (
    .clk(clk), .rst_n(rst_n), .project_done_flag(flag), .num_col(num_col), .num_row(num_row),
    .col_border_addr_rd(col_addr), .col_border_data_rd(col_data),
    .row_border_addr_rd(row_addr), .row_border_data_rd(row_data),
    .roi(roi_if), .seq_busy(busy), .seq_done(done), .seq_err(err), .seq_ovr(ovr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    col_data <= col_mem[col_addr[3:0]];
    row_data <= row_mem[row_addr[3:0]];
  end
  function automatic roi_t cur();
    return {roi_if.roi_x0, roi_if.roi_x1, roi_if.roi_y0, roi_if.roi_y1, roi_if.roi_idx, roi_if.roi_last};
  endfunction
  // frame-level reference: every (row, col) pair in row-major order, malformed pairs dropped
  function automatic void model(input int ncol, input int nrow);
    int nce, nre;
    nce = ncol > NUM_COL ? NUM_COL : ncol;
    nre = nrow > NUM_ROW ? NUM_ROW : nrow;
    exp_q.delete();
    exp_err = (ncol > NUM_COL) || (nrow > NUM_ROW);
    for (int rr = 0; rr < nre; rr++)
      for (int cc = 0; cc < nce; cc++)
        if (cb_hi[cc] <= cb_lo[cc] || rb_hi[rr] <= rb_lo[rr]) exp_err = 1;
        else exp_q.push_back({11'(cb_lo[cc]), 11'(cb_hi[cc]), 11'(rb_lo[rr]), 11'(rb_hi[rr]),
                              4'(rr * nce + cc), rr == nre - 1 && cc == nce - 1});
  endfunction
  // ready driver: settles before the monitor samples each cycle
  initial forever begin
    @(negedge clk);
    case (mode)
      0: roi_if.roi_ready = 1;
      1: roi_if.roi_ready = 1'($urandom_range(0, 1));
      2: if (roi_if.roi_valid && roi_if.roi_idx == 1 && stall < 7) begin
        roi_if.roi_ready = 0;
        stall++;
      end else roi_if.roi_ready = 1;
      default: roi_if.roi_ready = 0;
    endcase
  end
  // monitor: edge numbers refer to the next rising clock edge, where the DUT samples these values
  initial begin
    pv = 0;
    pr = 0;
    po = '0;
    forever begin
      @(negedge clk);
      #2;
      if (roi_if.roi_valid) begin
        valid_cnt++;
        if (!pv) rise_q.push_back(cyc + 1);
        if (pv && !pr && cur() !== po) stab_viol++;
        if (roi_if.roi_ready) begin
          got_q.push_back(cur());
          xfer_q.push_back(cyc + 1);
        end
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc + 1;
      end
      if (ovr) ovr_cnt++;
      pv = roi_if.roi_valid;
      pr = roi_if.roi_ready;
      po = cur();
    end
  end
  task automatic clear();
    got_q.delete();
    rise_q.delete();
    xfer_q.delete();
    done_cnt = 0;
    done_edge = 0;
    ovr_cnt = 0;
    stab_viol = 0;
    valid_cnt = 0;
    stall = 0;
  endtask
  task automatic set_default();
    cb_lo = '{10, 40, 70, 100};
    cb_hi = '{30, 60, 90, 120};
    rb_lo = '{5, 0};
    rb_hi = '{50, 0};
  endtask
  task automatic load_mem();
    for (int k = 0; k < 16; k++) begin
      col_mem[k] = '0;
      row_mem[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      col_mem[2*k+1] = 10'(cb_lo[k]);
      col_mem[2*k+2] = 10'(cb_hi[k]);
    end
    for (int k = 0; k < 2; k++) begin
      row_mem[2*k+1] = 10'(rb_lo[k]);
      row_mem[2*k+2] = 10'(rb_hi[k]);
    end
  endtask
  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cnt != 0) begin
        to = 0;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic run_seq(input int ncol, input int nrow, output bit to, output int t);
    load_mem();
    @(negedge clk);
    flag = 0;
    num_col = 4'(ncol);
    num_row = 4'(nrow);
    @(negedge clk);
    clear();
    flag = 1;
    t = cyc + 1;
    wait_done(to);
    flag = 0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (roi_if.roi_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", roi_if.roi_valid); end
    n_chk++; if (cur() !== '0) begin n_fail++; $display("FAIL reset_roi: got %h want 0", cur()); end
    n_chk++; if ({col_addr, row_addr} !== '0) begin n_fail++; $display("FAIL reset_addr: got %h/%h want 0", col_addr, row_addr); end
    n_chk++; if ({busy, done, err, ovr} !== 4'b0) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, done, err, ovr}); end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_single_row();
    bit to;
    int t;
    set_default();
    mode = 0;
    model(4, 1);
    run_seq(4, 1, to, t);
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", to); end
    n_chk++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_roi%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (rise_q.size() > 0) begin
      n_chk++; if (rise_q[0] - t !== 10) begin n_fail++; $display("FAIL single_first_latency: got %0d want 10", rise_q[0] - t); end
    end
    for (int i = 1; i < rise_q.size() && i <= xfer_q.size(); i++) begin
      n_chk++; if (rise_q[i] - xfer_q[i-1] !== 6) begin n_fail++; $display("FAIL single_gap%0d: got %0d want 6", i, rise_q[i] - xfer_q[i-1]); end
    end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL single_err: got %b want %b", err, exp_err); end
  endtask
  task automatic test_backpressure();
    bit to;
    int t;
    set_default();
    mode = 2;
    model(4, 1);
    run_seq(4, 1, to, t);
    mode = 0;
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL bp_timeout: got %b want 0", to); end
    n_chk++; if (stall !== 7) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 7", stall); end
    n_chk++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", stab_viol); end
    n_chk++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_roi%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_malformed();
    bit to;
    int t;
    set_default();
    cb_lo[2] = 50;
    cb_hi[2] = 40;
    mode = 0;
    model(4, 1);
    run_seq(4, 1, to, t);
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL bad_timeout: got %b want 0", to); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b want 1", err); end
    n_chk++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL bad_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bad_roi%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_clamp();
    bit to;
    int t;
    set_default();
    mode = 0;
    model(6, 1);
    run_seq(6, 1, to, t);
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL clamp_timeout: got %b want 0", to); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %b want 1", err); end
    n_chk++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL clamp_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_roi%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_empty();
    bit to;
    int t;
    set_default();
    mode = 0;
    run_seq(0, 1, to, t);
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL empty_timeout: got %b want 0", to); end
    n_chk++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL empty_valid: got %0d want 0", valid_cnt); end
    n_chk++; if (done_edge - t !== 1) begin n_fail++; $display("FAIL empty_done_latency: got %0d want 1", done_edge - t); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL empty_err: got %b want 0", err); end
  endtask
  task automatic test_retrigger();
    bit to;
    set_default();
    mode = 0;
    model(4, 1);
    load_mem();
    @(negedge clk);
    flag = 0;
    num_col = 4;
    num_row = 1;
    @(negedge clk);
    clear();
    flag = 1;
    repeat (12) @(negedge clk);
    flag = 0;
    @(negedge clk);
    flag = 1;
    wait_done(to);
    repeat (5) @(negedge clk);
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL retrig_timeout: got %b want 0", to); end
    n_chk++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL retrig_ovr: got %0d want 1", ovr_cnt); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL retrig_done: got %0d want 1", done_cnt); end
    n_chk++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL retrig_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL retrig_roi%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    flag = 0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    bit to;
    set_default();
    mode = 3;
    load_mem();
    @(negedge clk);
    flag = 0;
    num_col = 4;
    num_row = 1;
    @(negedge clk);
    clear();
    flag = 1;
    to = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (roi_if.roi_valid) begin
        to = 0;
        break;
      end
    end
    n_chk++; if (to !== 0) begin n_fail++; $display("FAIL rstmid_reach_present: got timeout %b want 0", to); end
    #1 rst_n = 0;
    #1;
    n_chk++; if ({roi_if.roi_valid, roi_if.roi_last, busy, done} !== 4'b0) begin n_fail++; $display("FAIL rstmid_status: got %b want 0000", {roi_if.roi_valid, roi_if.roi_last, busy, done}); end
    n_chk++; if (cur() !== '0) begin n_fail++; $display("FAIL rstmid_roi: got %h want 0", cur()); end
    n_chk++; if ({col_addr, row_addr} !== '0) begin n_fail++; $display("FAIL rstmid_addr: got %h/%h want 0", col_addr, row_addr); end
    repeat (3) @(negedge clk);
    flag = 0;
    n_chk++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
    @(negedge clk);
    rst_n = 1;
    mode = 0;
    @(negedge clk);
  endtask
  task automatic test_random();
    bit to;
    int t, ncol, nrow;
    mode = 1;
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++) begin
        cb_lo[k] = $urandom_range(0, 1000);
        cb_hi[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, cb_lo[k]) : $urandom_range(cb_lo[k] + 1, 1023);
      end
      for (int k = 0; k < 2; k++) begin
        rb_lo[k] = $urandom_range(0, 1000);
        rb_hi[k] = ($urandom_range(0, 6) == 0) ? $urandom_range(0, rb_lo[k]) : $urandom_range(rb_lo[k] + 1, 1023);
      end
      ncol = $urandom_range(0, 6);
      nrow = $urandom_range(0, 2);
      model(ncol, nrow);
      run_seq(ncol, nrow, to, t);
      n_chk++; if (to !== 0) begin n_fail++; $display("FAIL rnd%0d_timeout: got %b want 0", it, to); end
      n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", it, err, exp_err); end
      n_chk++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_roi%0d: got %h want %h", it, i, got_q[i], exp_q[i]); end
      end
    end
    mode = 0;
  endtask
  initial begin
    roi_if.roi_ready = 1;
    set_default();
    load_mem();
    test_reset();
    test_single_row();
    test_backpressure();
    test_malformed();
    test_clamp();
    test_empty();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
